alu_issue_seq: RTL

Multi-cycle issue/writeback sequencer that drives the processor ALU.
- Accepts one 9-bit instruction per valid/ready handshake.
- Reads operands from the register file and presents Aluop, Imm, DatA and DatB to the ALU.
- Captures Rslt, Zero, Par, Jen and SCo, then performs register writeback or raises a branch-taken pulse.
- Sits between fetch and the ALU/register file; the consumer end of the ALU's result/flag interface.

---
 rtl/alu_issue_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_issue_seq
//  Purpose  : Four-state issue/writeback sequencer feeding the ALU.
//             Optional macro CARRY_FLAG_EN adds a sticky CarryFlag output.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_seq #(
  parameter int DW   = 8,
  parameter int IW   = 9,
  parameter int RA_W = 3
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            InstValid,
  input  logic [IW-1:0]   Inst,
  output logic            InstReady,
  output logic [RA_W-1:0] RdAddrA,
  output logic [RA_W-1:0] RdAddrB,
  input  logic [DW-1:0]   RdDatA,
  input  logic [DW-1:0]   RdDatB,
  output logic [3:0]      Aluop,
  output logic [2:0]      Imm,
  output logic [DW-1:0]   DatA,
  output logic [DW-1:0]   DatB,
  input  logic [DW-1:0]   Rslt,
  input  logic            Zero,
  input  logic            Par,
  input  logic            Jen,
  input  logic            SCo,
  output logic            WrEn,
  output logic [RA_W-1:0] WrAddr,
  output logic [DW-1:0]   WrDat,
  output logic            BranchTaken,
  output logic            IllegalOp,
`ifdef CARRY_FLAG_EN
  output logic            CarryFlag,
`endif
  output logic            ZeroFlag,
  output logic            ParFlag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   inst_q;
  logic [DW-1:0]   opa_q;
  logic [DW-1:0]   opb_q;

  logic [3:0]      w_op;
  logic [1:0]      w_rd;
  logic [2:0]      w_rs;
  logic            w_op_write;
  logic            w_op_cmp;
  logic            w_op_ill;
  logic [RA_W-1:0] w_rd_addr;

  assign w_op      = inst_q[8:5];
  assign w_rs      = inst_q[4:2];
  assign w_rd      = inst_q[1:0];
  assign w_rd_addr = {{(RA_W-2){1'b0}}, w_rd};

  assign w_op_write = (w_op <= 4'd5) || ((w_op >= 4'd8) && (w_op <= 4'd11));
  assign w_op_cmp   = (w_op == 4'd6) || (w_op == 4'd7);
  assign w_op_ill   = (w_op >= 4'd12);

  // Operand/opcode outputs come straight from the instruction and operand
  // registers, so they simply hold outside the states where they matter.
  assign RdAddrA = w_rd_addr;
  assign RdAddrB = RA_W'(w_rs);
  assign Aluop   = w_op;
  assign Imm     = w_rs;
  assign DatA    = opa_q;
  assign DatB    = opb_q;

`ifdef CARRY_FLAG_EN
  logic w_op_carry;
  assign w_op_carry = (w_op == 4'd0) || (w_op == 4'd1) || (w_op == 4'd2) ||
                      (w_op == 4'd10) || (w_op == 4'd11);
`else
  logic w_unused_sco;
  assign w_unused_sco = SCo;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      inst_q      <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      InstReady   <= 1'b1;
      WrEn        <= 1'b0;
      WrAddr      <= '0;
      WrDat       <= '0;
      BranchTaken <= 1'b0;
      IllegalOp   <= 1'b0;
      ZeroFlag    <= 1'b0;
      ParFlag     <= 1'b0;
`ifdef CARRY_FLAG_EN
      CarryFlag   <= 1'b0;
`endif
    end else begin
      WrEn        <= 1'b0;
      BranchTaken <= 1'b0;
      IllegalOp   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (InstValid && InstReady) begin
            inst_q    <= Inst;
            InstReady <= 1'b0;
            state_q   <= S_READ;
          end
        end
        S_READ: begin
          opa_q   <= RdDatA;
          opb_q   <= RdDatB;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // ALU results are captured directly into the writeback/flag
          // registers so the WB-cycle strobes appear as registered outputs.
          WrEn        <= w_op_write;
          WrAddr      <= w_rd_addr;
          WrDat       <= Rslt;
          BranchTaken <= w_op_cmp & Jen;
          IllegalOp   <= w_op_ill;
          if (w_op_write) begin
            ZeroFlag <= Zero;
            ParFlag  <= Par;
          end
`ifdef CARRY_FLAG_EN
          if (w_op_carry) begin
            CarryFlag <= SCo;
          end
`endif
          state_q <= S_WB;
        end
        S_WB: begin
          InstReady <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          InstReady <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
